// File: rtl/fpu_rr_arbiter.sv
// rtl/fpu_rr_arbiter.sv - round-robin arbiter sharing one tagged FPU between requesters
//
// Purpose: grants one of NUM_REQ requesters onto a single valid/ready FPU
// input port (round-robin, grant held until accepted), routes each result
// back to its requester by tag, and limits in-flight operations to MAX_OUT.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_valid_i/ready_o per-requester issue handshake
//   req_operands_i      requester r operands at slice r (NUM_OPERANDS*WIDTH each)
//   req_op_i, req_rnd_i per-requester operation code / rounding mode
//   fpu_in_*            granted operation towards the FPU, fpu_tag_o = requester
//   fpu_out_*           FPU result port, fpu_tag_i selects the requester
//   rsp_valid_o/ready_i per-requester result handshake
//   rsp_result_o/status shared result bus
//   busy_o              locked grant or operations in flight
//   err_o               one-cycle pulse on a protocol error
module fpu_rr_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int WIDTH        = 16,
  parameter int NUM_OPERANDS = 3,
  parameter int OP_W         = 4,
  parameter int MAX_OUT      = 4,
  localparam int ID_W        = $clog2(NUM_REQ),
  localparam int CNT_W       = $clog2(MAX_OUT + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*NUM_OPERANDS*WIDTH-1:0] req_operands_i,
  input  logic [NUM_REQ*OP_W-1:0]           req_op_i,
  input  logic [NUM_REQ*3-1:0]              req_rnd_i,
  output logic                              fpu_in_valid_o,
  input  logic                              fpu_in_ready_i,
  output logic [NUM_OPERANDS*WIDTH-1:0]     fpu_operands_o,
  output logic [OP_W-1:0]                   fpu_op_o,
  output logic [2:0]                        fpu_rnd_o,
  output logic [ID_W-1:0]                   fpu_tag_o,
  input  logic                              fpu_out_valid_i,
  output logic                              fpu_out_ready_o,
  input  logic [WIDTH-1:0]                  fpu_result_i,
  input  logic [4:0]                        fpu_status_i,
  input  logic [ID_W-1:0]                   fpu_tag_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  input  logic [NUM_REQ-1:0]                rsp_ready_i,
  output logic [WIDTH-1:0]                  rsp_result_o,
  output logic [4:0]                        rsp_status_o,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int OPS_W = NUM_OPERANDS * WIDTH;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  lock_id;
  logic [CNT_W-1:0] cnt;

  logic            found;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] idx_v;
  logic [ID_W-1:0] grant;
  logic            cnt_full;
  logic            lock_drop;
  logic            issue;
  logic            tag_ok;
  logic            retire;
  logic            dec;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  // First valid requester scanning upward from rr_ptr with wrap-around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx_v = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid_i[idx_v]) begin
        found = 1'b1;
        pick  = idx_v;
      end
      idx_v = next_id(idx_v);
    end
  end

  assign cnt_full  = (cnt == CNT_W'(MAX_OUT));
  assign grant     = (state == ST_LOCKED) ? lock_id : pick;
  // A locked requester that withdraws its request is not issued on its behalf.
  assign lock_drop = (state == ST_LOCKED) && !req_valid_i[lock_id];

  always_comb begin
    fpu_in_valid_o = 1'b0;
    if (!rst_i) begin
      if (state == ST_LOCKED) fpu_in_valid_o = !lock_drop;
      else                    fpu_in_valid_o = found && !cnt_full;
    end
  end

  assign issue = fpu_in_valid_o && fpu_in_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (issue) req_ready_o[grant] = 1'b1;
  end

  assign fpu_operands_o = req_operands_i[int'(grant)*OPS_W +: OPS_W];
  assign fpu_op_o       = req_op_i[int'(grant)*OP_W +: OP_W];
  assign fpu_rnd_o      = req_rnd_i[int'(grant)*3 +: 3];
  assign fpu_tag_o      = grant;

  // Response side: out-of-range tags are swallowed so the FPU never stalls.
  assign tag_ok = (int'(fpu_tag_i) < NUM_REQ);

  always_comb begin
    rsp_valid_o     = '0;
    fpu_out_ready_o = 1'b0;
    if (!rst_i) begin
      if (tag_ok) begin
        rsp_valid_o[fpu_tag_i] = fpu_out_valid_i;
        fpu_out_ready_o        = rsp_ready_i[fpu_tag_i];
      end else begin
        fpu_out_ready_o = 1'b1;
      end
    end
  end

  assign rsp_result_o = fpu_result_i;
  assign rsp_status_o = fpu_status_i;

  assign retire = fpu_out_valid_i && fpu_out_ready_o;
  assign dec    = retire && (cnt != '0);
  assign busy_o = (state == ST_LOCKED) || (cnt != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
      cnt     <= '0;
      err_o   <= 1'b0;
    end else begin
      err_o <= lock_drop || (retire && (cnt == '0)) || (fpu_out_valid_i && !tag_ok);

      if (issue && !dec)      cnt <= cnt + CNT_W'(1);
      else if (!issue && dec) cnt <= cnt - CNT_W'(1);

      case (state)
        ST_IDLE: begin
          if (issue) begin
            rr_ptr <= next_id(grant);
          end else if (fpu_in_valid_o) begin
            lock_id <= grant;
            state   <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (lock_drop) begin
            state <= ST_IDLE;
          end else if (issue) begin
            rr_ptr <= next_id(lock_id);
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// tb/tb_fpu_rr_arbiter.sv - directed self-checking bench for fpu_rr_arbiter
module tb_fpu_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Two-requester instance
  logic [1:0]  req_valid, req_ready;
  logic [95:0] req_operands;
  logic [7:0]  req_op;
  logic [5:0]  req_rnd;
  logic        in_valid, in_ready;
  logic [47:0] fpu_operands;
  logic [3:0]  fpu_op;
  logic [2:0]  fpu_rnd;
  logic [0:0]  fpu_tag;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic [4:0]  status;
  logic [0:0]  tag_i;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [4:0]  rsp_status;
  logic        busy, err;

  // Three-requester instance, used for the out-of-range tag case
  logic [2:0]   d3_req_valid, d3_req_ready;
  logic [143:0] d3_req_operands;
  logic [11:0]  d3_req_op;
  logic [8:0]   d3_req_rnd;
  logic         d3_in_valid, d3_in_ready;
  logic [47:0]  d3_fpu_operands;
  logic [3:0]   d3_fpu_op;
  logic [2:0]   d3_fpu_rnd;
  logic [1:0]   d3_fpu_tag;
  logic         d3_out_valid, d3_out_ready;
  logic [15:0]  d3_result;
  logic [4:0]   d3_status;
  logic [1:0]   d3_tag_i;
  logic [2:0]   d3_rsp_valid, d3_rsp_ready;
  logic [15:0]  d3_rsp_result;
  logic [4:0]   d3_rsp_status;
  logic         d3_busy, d3_err;

  fpu_rr_arbiter #(.NUM_REQ(2), .WIDTH(16), .NUM_OPERANDS(3), .OP_W(4), .MAX_OUT(4)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_operands),
    .req_op_i(req_op), .req_rnd_i(req_rnd),
    .fpu_in_valid_o(in_valid), .fpu_in_ready_i(in_ready), .fpu_operands_o(fpu_operands),
    .fpu_op_o(fpu_op), .fpu_rnd_o(fpu_rnd), .fpu_tag_o(fpu_tag),
    .fpu_out_valid_i(out_valid), .fpu_out_ready_o(out_ready), .fpu_result_i(result),
    .fpu_status_i(status), .fpu_tag_i(tag_i),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_status_o(rsp_status), .busy_o(busy), .err_o(err)
  );

  fpu_rr_arbiter #(.NUM_REQ(3), .WIDTH(16), .NUM_OPERANDS(3), .OP_W(4), .MAX_OUT(4)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(d3_req_valid), .req_ready_o(d3_req_ready), .req_operands_i(d3_req_operands),
    .req_op_i(d3_req_op), .req_rnd_i(d3_req_rnd),
    .fpu_in_valid_o(d3_in_valid), .fpu_in_ready_i(d3_in_ready), .fpu_operands_o(d3_fpu_operands),
    .fpu_op_o(d3_fpu_op), .fpu_rnd_o(d3_fpu_rnd), .fpu_tag_o(d3_fpu_tag),
    .fpu_out_valid_i(d3_out_valid), .fpu_out_ready_o(d3_out_ready), .fpu_result_i(d3_result),
    .fpu_status_i(d3_status), .fpu_tag_i(d3_tag_i),
    .rsp_valid_o(d3_rsp_valid), .rsp_ready_i(d3_rsp_ready), .rsp_result_o(d3_rsp_result),
    .rsp_status_o(d3_rsp_status), .busy_o(d3_busy), .err_o(d3_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge, outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 2'b11;
    req_operands = {48'h1111_2222_3333, 48'h4444_5555_6666};
    req_op       = {4'h5, 4'h3};
    req_rnd      = {3'd2, 3'd1};
    in_ready     = 1'b1;
    out_valid    = 1'b0;
    result       = 16'h0000;
    status       = 5'h00;
    tag_i        = 1'b0;
    rsp_ready    = 2'b11;
    d3_req_valid = 3'b000;
    d3_req_operands = '0;
    d3_req_op    = '0;
    d3_req_rnd   = '0;
    d3_in_ready  = 1'b0;
    d3_out_valid = 1'b0;
    d3_result    = '0;
    d3_status    = '0;
    d3_tag_i     = '0;
    d3_rsp_ready = '0;

    // 1. Reset with all requesters valid
    tick(); #1;
    check("rst_in_valid", in_valid, 0);
    check("rst_req_ready", req_ready, 2'b00);
    tick(); #1;
    check("rst_in_valid2", in_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0; #1;

    // 2. Fairness, results returned one cycle after issue
    check("fair0_valid", in_valid, 1);
    check("fair0_tag", fpu_tag, 0);
    check("fair0_ready", req_ready, 2'b01);
    check("fair0_operands", fpu_operands, 48'h4444_5555_6666);
    check("fair0_op", fpu_op, 4'h3);
    tick();
    out_valid = 1'b1; tag_i = 1'b0; #1;
    check("fair1_tag", fpu_tag, 1);
    check("fair1_ready", req_ready, 2'b10);
    check("fair1_rsp_valid", rsp_valid, 2'b01);
    tick();
    tag_i = 1'b1; #1;
    check("fair2_tag", fpu_tag, 0);
    check("fair2_ready", req_ready, 2'b01);
    tick();
    tag_i = 1'b0; #1;
    check("fair3_tag", fpu_tag, 1);
    check("fair3_ready", req_ready, 2'b10);
    tick();
    // issue+retire each cycle kept cnt at 1; one more retire empties it
    req_valid = 2'b00; tag_i = 1'b1; #1;
    check("fair_busy_cnt1", busy, 1);
    tick();
    out_valid = 1'b0; #1;
    check("fair_busy_drained", busy, 0);

    // 3. Grant lock
    req_valid = 2'b10; in_ready = 1'b0; #1;
    check("lock_c0_tag", fpu_tag, 1);
    check("lock_c0_ready", req_ready, 2'b00);
    tick();
    req_valid = 2'b11; #1;
    check("lock_c1_tag", fpu_tag, 1);
    check("lock_c1_operands", fpu_operands, 48'h1111_2222_3333);
    check("lock_c1_rnd", fpu_rnd, 3'd2);
    check("lock_busy", busy, 1);
    tick(); #1;
    check("lock_c2_tag", fpu_tag, 1);
    check("lock_c2_valid", in_valid, 1);
    tick();
    in_ready = 1'b1; #1;
    check("lock_c3_ready", req_ready, 2'b10);
    tick(); #1;

    // 4. Throttle: cnt=1 here, three more issues reach MAX_OUT
    check("thr_tag0", fpu_tag, 0);
    check("thr_ready0", req_ready, 2'b01);
    tick(); #1;
    check("thr_tag1", fpu_tag, 1);
    tick(); #1;
    check("thr_tag0b", fpu_tag, 0);
    tick(); #1;
    check("thr_full_valid", in_valid, 0);
    check("thr_full_ready", req_ready, 2'b00);
    check("thr_full_busy", busy, 1);
    out_valid = 1'b1; tag_i = 1'b1; rsp_ready = 2'b11; #1;
    check("thr_ret_rsp_valid", rsp_valid, 2'b10);
    check("thr_ret_out_ready", out_ready, 1);
    check("thr_ret_in_valid", in_valid, 0);
    tick();
    out_valid = 1'b0; #1;
    check("thr_resume_valid", in_valid, 1);
    check("thr_resume_tag", fpu_tag, 1);
    tick();

    // 5. Response routing, cnt=4
    req_valid = 2'b00; in_ready = 1'b0;
    out_valid = 1'b1; tag_i = 1'b1; result = 16'h3C00; status = 5'h01; rsp_ready = 2'b00; #1;
    check("rsp_c0_valid", rsp_valid, 2'b10);
    check("rsp_c0_out_ready", out_ready, 0);
    check("rsp_result", rsp_result, 16'h3C00);
    check("rsp_status", rsp_status, 5'h01);
    tick(); #1;
    check("rsp_c1_valid", rsp_valid, 2'b10);
    check("rsp_c1_out_ready", out_ready, 0);
    rsp_ready = 2'b10; #1;
    check("rsp_hs_out_ready", out_ready, 1);
    tick();
    out_valid = 1'b0; req_valid = 2'b01; #1;
    check("rsp_cnt_dec", in_valid, 1);
    req_valid = 2'b00;
    out_valid = 1'b1; tag_i = 1'b0; rsp_ready = 2'b11;
    tick(); tick(); tick();
    out_valid = 1'b0; #1;
    check("rsp_drained_busy", busy, 0);
    check("rsp_drained_err", err, 0);

    // 6. Errors: retire at cnt=0
    out_valid = 1'b1; tag_i = 1'b0;
    tick();
    out_valid = 1'b0; #1;
    check("err_uf_pulse", err, 1);
    check("err_uf_busy", busy, 0);
    tick(); #1;
    check("err_uf_clear", err, 0);

    // locked requester withdraws its request
    req_valid = 2'b01; in_ready = 1'b0;
    tick();
    req_valid = 2'b00; #1;
    check("err_drop_busy", busy, 1);
    tick(); #1;
    check("err_drop_pulse", err, 1);
    check("err_drop_idle", busy, 0);
    tick(); #1;
    check("err_drop_clear", err, 0);

    // out-of-range tag with NUM_REQ=3
    d3_req_valid = 3'b001; d3_in_ready = 1'b1; #1;
    check("d3_issue_ready", d3_req_ready, 3'b001);
    tick();
    d3_req_valid = 3'b000;
    d3_out_valid = 1'b1; d3_tag_i = 2'd3; #1;
    check("d3_bad_out_ready", d3_out_ready, 1);
    check("d3_bad_rsp_valid", d3_rsp_valid, 3'b000);
    check("d3_bad_busy", d3_busy, 1);
    tick();
    d3_out_valid = 1'b0; #1;
    check("d3_bad_err", d3_err, 1);
    check("d3_bad_cnt_dec", d3_busy, 0);
    tick(); #1;
    check("d3_bad_err_clear", d3_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
